// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester turning cmd/rsp handshakes into SETUP/ACCESS transfers with a wait timeout
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic live, done, tmo;
  logic [7:0] cnt;
  // live keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = live && state == IDLE;
  assign psel      = state == SETUP || state == ACCESS;
  assign penable   = state == ACCESS;
  assign rsp_valid = state == RESP;
  assign done      = state == ACCESS && pready;
  assign tmo       = state == ACCESS && !pready && cnt == 8'(TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (cmd_valid && cmd_ready) ? SETUP : IDLE;
      SETUP:   state_nx = ACCESS;
      ACCESS:  state_nx = (done || tmo) ? RESP : ACCESS;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      live        <= 1'b0;
      cnt         <= '0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
      cnt   <= state == SETUP ? 8'd0 : (state == ACCESS && !pready) ? cnt + 8'd1 : cnt;
      if (cmd_valid && cmd_ready) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_write ? cmd_wdata : '0;
      end
      if (done) begin
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (tmo) begin
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b0;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of the APB requester; inputs change and outputs are sampled 1ns after each rising edge
module tb_apb_master;
  logic pclk = 0, presetn = 0, cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
  logic pready = 0, pslverr = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0, prdata = 0;
  logic cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, psel, penable, pwrite;
  logic [31:0] rsp_rdata, paddr, pwdata;
  int checks = 0, failures = 0;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready),
    .pslverr(pslverr), .prdata(prdata));

  always #5 pclk = ~pclk;

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset;
    tick; tick;
    checks++; if (psel !== 0 || penable !== 0) begin failures++; $display("FAIL rst_psel got=%b%b exp=00", psel, penable); end
    checks++; if (cmd_ready !== 0) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if (rsp_valid !== 0 || rsp_slverr !== 0 || rsp_timeout !== 0) begin failures++; $display("FAIL rst_rsp got=%b%b%b exp=000", rsp_valid, rsp_slverr, rsp_timeout); end
    checks++; if (paddr !== 0 || pwdata !== 0 || pwrite !== 0 || rsp_rdata !== 0) begin failures++; $display("FAIL rst_regs got=%h %h %b %h exp=0", paddr, pwdata, pwrite, rsp_rdata); end
    presetn = 1;
    #1;
    checks++; if (cmd_ready !== 0) begin failures++; $display("FAIL rst_release_ready got=%b exp=0", cmd_ready); end
    tick;
    checks++; if (cmd_ready !== 1) begin failures++; $display("FAIL rst_first_edge_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEAD_BEEF;
    pready = 1; prdata = 32'hCAFE_F00D; rsp_ready = 1;
    tick;
    cmd_valid = 0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    checks++; if (psel !== 1 || penable !== 0 || cmd_ready !== 0) begin failures++; $display("FAIL wr_setup_ctrl got=%b%b%b exp=100", psel, penable, cmd_ready); end
    checks++; if (paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1) begin failures++; $display("FAIL wr_setup_bus got=%h %h %b exp=00000010 deadbeef 1", paddr, pwdata, pwrite); end
    tick;
    checks++; if (psel !== 1 || penable !== 1) begin failures++; $display("FAIL wr_access_ctrl got=%b%b exp=11", psel, penable); end
    checks++; if (paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1) begin failures++; $display("FAIL wr_access_bus got=%h %h %b exp=00000010 deadbeef 1", paddr, pwdata, pwrite); end
    tick;
    checks++; if (rsp_valid !== 1 || rsp_slverr !== 0 || rsp_timeout !== 0 || rsp_rdata !== 0) begin failures++; $display("FAIL wr_resp got=%b%b%b %h exp=100 0", rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata); end
    checks++; if (psel !== 0 || penable !== 0 || paddr !== 32'h10 || pwrite !== 1) begin failures++; $display("FAIL wr_resp_bus got=%b%b %h %b exp=00 10 1", psel, penable, paddr, pwrite); end
    tick;
    checks++; if (rsp_valid !== 0 || cmd_ready !== 1) begin failures++; $display("FAIL wr_idle got=%b%b exp=01", rsp_valid, cmd_ready); end
    pready = 0; rsp_ready = 0;
  endtask

  task automatic test_read_wait;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h4; cmd_wdata = 32'h5555_5555;
    tick;
    cmd_valid = 0;
    checks++; if (pwdata !== 0 || pwrite !== 0 || paddr !== 32'h4) begin failures++; $display("FAIL rd_setup_bus got=%h %b %h exp=0 0 4", pwdata, pwrite, paddr); end
    tick;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (penable !== 1 || paddr !== 32'h4) begin failures++; $display("FAIL rd_access_%0d got=%b %h exp=1 4", i, penable, paddr); end
      if (i == 4) begin pready = 1; prdata = 32'h1234_5678; end
      tick;
    end
    pready = 0; prdata = 32'h0;
    checks++; if (penable !== 0 || rsp_valid !== 1) begin failures++; $display("FAIL rd_end got=%b%b exp=01", penable, rsp_valid); end
    checks++; if (rsp_rdata !== 32'h1234_5678 || rsp_timeout !== 0) begin failures++; $display("FAIL rd_data got=%h %b exp=12345678 0", rsp_rdata, rsp_timeout); end
    rsp_ready = 1; tick; rsp_ready = 0;
  endtask

  task automatic test_timeout;
    int n;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8;
    prdata = 32'hFFFF_FFFF; pslverr = 1;
    tick; cmd_valid = 0; tick;
    n = 0;
    while (penable === 1 && n < 40) begin n++; tick; end
    checks++; if (n !== 16) begin failures++; $display("FAIL to_access_len got=%0d exp=16", n); end
    checks++; if (psel !== 0 || rsp_valid !== 1) begin failures++; $display("FAIL to_resp got=%b%b exp=01", psel, rsp_valid); end
    checks++; if (rsp_timeout !== 1 || rsp_rdata !== 0 || rsp_slverr !== 0) begin failures++; $display("FAIL to_fields got=%b %h %b exp=1 0 0", rsp_timeout, rsp_rdata, rsp_slverr); end
    rsp_ready = 1; tick; rsp_ready = 0;
    pslverr = 0; cmd_valid = 1; cmd_addr = 32'hC;
    tick; cmd_valid = 0; tick;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin pready = 1; prdata = 32'hA5A5_0016; end
      tick;
    end
    pready = 0;
    checks++; if (rsp_valid !== 1 || rsp_timeout !== 0 || rsp_rdata !== 32'hA5A5_0016) begin failures++; $display("FAIL to_edge got=%b %b %h exp=1 0 a5a50016", rsp_valid, rsp_timeout, rsp_rdata); end
    rsp_ready = 1; tick; rsp_ready = 0;
  endtask

  task automatic test_slverr;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'h0BAD_0BAD;
    pready = 1; pslverr = 1;
    tick; cmd_valid = 0; tick; tick;
    pready = 0; pslverr = 0;
    cmd_valid = 1; cmd_addr = 32'hBAD0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (rsp_valid !== 1 || rsp_slverr !== 1 || cmd_ready !== 0) begin failures++; $display("FAIL se_hold_%0d got=%b%b%b exp=110", i, rsp_valid, rsp_slverr, cmd_ready); end
      checks++; if (paddr !== 32'h20) begin failures++; $display("FAIL se_addr_%0d got=%h exp=20", i, paddr); end
      if (i == 5) begin rsp_ready = 1; cmd_valid = 0; end
      tick;
    end
    checks++; if (rsp_valid !== 0 || cmd_ready !== 1) begin failures++; $display("FAIL se_release got=%b%b exp=01", rsp_valid, cmd_ready); end
    rsp_ready = 0;
  endtask

  task automatic test_back_to_back;
    logic e;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h100; cmd_wdata = 32'h1000;
    rsp_ready = 1; pready = 1;
    for (int i = 0; i < 12; i++) begin
      e = (i % 4 == 0);
      checks++; if (cmd_ready !== e) begin failures++; $display("FAIL b2b_ready_%0d got=%b exp=%b", i, cmd_ready, e); end
      e = (i % 4 == 1) || (i % 4 == 2);
      checks++; if (psel !== e) begin failures++; $display("FAIL b2b_psel_%0d got=%b exp=%b", i, psel, e); end
      if (i % 4 == 1) begin
        checks++; if (paddr !== 32'h100 + 32'(4 * (i / 4))) begin failures++; $display("FAIL b2b_addr_%0d got=%h exp=%h", i, paddr, 32'h100 + 32'(4 * (i / 4))); end
        cmd_addr = cmd_addr + 4;
      end
      if (i == 11) cmd_valid = 0;
      tick;
    end
    rsp_ready = 0; pready = 0;
  endtask

  task automatic test_reset_mid;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30;
    tick; cmd_valid = 0; tick; tick;
    #2 presetn = 0;
    #1;
    checks++; if (psel !== 0 || penable !== 0 || cmd_ready !== 0 || rsp_valid !== 0) begin failures++; $display("FAIL rm_async got=%b%b%b%b exp=0000", psel, penable, cmd_ready, rsp_valid); end
    checks++; if (paddr !== 0) begin failures++; $display("FAIL rm_addr got=%h exp=0", paddr); end
    tick;
    presetn = 1;
    pready = 1; prdata = 32'h7777_7777;
    tick;
    checks++; if (cmd_ready !== 1 || rsp_valid !== 0) begin failures++; $display("FAIL rm_release got=%b%b exp=10", cmd_ready, rsp_valid); end
    tick;
    checks++; if (rsp_valid !== 0 || psel !== 0) begin failures++; $display("FAIL rm_idle got=%b%b exp=00", rsp_valid, psel); end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h4444_4444; rsp_ready = 1;
    tick; cmd_valid = 0;
    checks++; if (psel !== 1 || paddr !== 32'h40 || pwdata !== 32'h4444_4444) begin failures++; $display("FAIL rm_setup got=%b %h %h exp=1 40 44444444", psel, paddr, pwdata); end
    tick; tick;
    checks++; if (rsp_valid !== 1 || rsp_rdata !== 0 || rsp_timeout !== 0) begin failures++; $display("FAIL rm_resp got=%b %h %b exp=1 0 0", rsp_valid, rsp_rdata, rsp_timeout); end
    tick;
    checks++; if (cmd_ready !== 1) begin failures++; $display("FAIL rm_done got=%b exp=1", cmd_ready); end
    pready = 0; rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write;
    test_read_wait;
    test_timeout;
    test_slverr;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 32, width of cmd_addr and paddr.
REQ-002 Parameter DATA_W, default 32, width of all data buses.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles without pready before abort (legal range 1..255).
REQ-004 pclk  input  1  single clock; all state changes on rising edge.
REQ-005 presetn  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  transfer address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumer ready.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes and timeouts.
REQ-014 rsp_slverr  output  1  captured pslverr.
REQ-015 rsp_timeout  output  1  transfer aborted by timeout.
REQ-016 psel, penable, pwrite  output  1 each  APB control.
REQ-017 paddr  output  ADDR_W; pwdata  output  DATA_W  APB address/write data.
REQ-018 pready, pslverr  input  1 each; prdata  input  DATA_W  APB completer response.

Function
REQ-019 FSM states IDLE, SETUP, ACCESS, RESP; one transfer outstanding at a time.
REQ-020 cmd_ready = 1 only in IDLE; command accepted on cmd_valid && cmd_ready; write/addr/wdata registered; next state SETUP.
REQ-021 SETUP: psel=1, penable=0, paddr/pwrite/pwdata from registered command; pwdata=0 for reads; lasts exactly 1 cycle, then ACCESS.
REQ-022 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata identical to SETUP values every cycle.
REQ-023 ACCESS with pready=1: capture prdata (reads only, else 0) into rsp_rdata, pslverr into rsp_slverr, rsp_timeout=0; next state RESP.
REQ-024 Wait counter (8 bit) clears on entering ACCESS, increments each ACCESS cycle with pready=0; when it reaches TIMEOUT with pready still 0, next state RESP with rsp_timeout=1, rsp_slverr=0, rsp_rdata=0.
REQ-025 pready=1 in the same cycle the counter reaches TIMEOUT: normal completion wins, rsp_timeout=0.
REQ-026 RESP: psel=0, penable=0; rsp_valid=1 and response fields held stable until rsp_valid && rsp_ready, then IDLE.
REQ-027 Minimum transfer: accept cycle, SETUP, ACCESS, RESP -> next command accepted no earlier than 4 cycles after previous acceptance with rsp_ready tied 1.
REQ-028 pready, pslverr, prdata ignored outside ACCESS.
REQ-029 In IDLE and RESP, paddr/pwdata/pwrite hold last driven values; psel=penable=0.
REQ-030 cmd_* inputs ignored when cmd_ready=0.

Reset
REQ-031 presetn low asynchronously forces state IDLE, all outputs 0 except cmd_ready (0 while presetn low, 1 from first edge after release), wait counter 0, registered command 0.
REQ-032 Reset during SETUP/ACCESS/RESP drops psel/penable immediately; in-flight transfer and pending response discarded, no rsp_valid after release.

Verification
REQ-033 Write 0x0000_0010 <- 0xDEAD_BEEF, pready=1 in first ACCESS -> SETUP then ACCESS with stable paddr/pwdata, pwrite=1; rsp_valid one cycle later, rsp_slverr=0, rsp_rdata=0.
REQ-034 Read 0x0000_0004, completer inserts 3 wait states then prdata=0x1234_5678 -> penable high 4 cycles; rsp_rdata=0x1234_5678, rsp_timeout=0.
REQ-035 Read with pready held 0, TIMEOUT=16 -> ACCESS lasts 16 cycles, psel drops, rsp_timeout=1, rsp_rdata=0; then pready=1 on cycle 16 of a repeat -> rsp_timeout=0.
REQ-036 Write with pslverr=1 at completion, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_slverr=1 stable 6 cycles; cmd_ready=0 throughout.
REQ-037 Back-to-back writes with cmd_valid and rsp_ready tied 1 -> acceptances every 4 cycles, psel low exactly 2 cycles between transfers.
REQ-038 presetn asserted mid-ACCESS -> psel/penable 0 in same cycle; after release cmd_ready=1, no rsp_valid, next command completes normally.
